// File: rtl/div_unit.sv
// Iterative restoring divider for the EX stage: one quotient bit per cycle,
// stalls the pipeline until the result is ready, signed or unsigned operands.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             stall_es,
  input  logic             div_valid,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             stallreq_es,
  output logic             div_done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   trial;
  logic [WIDTH+1:0] diff;
  logic             qbit;
  logic [WIDTH-1:0] rem_step, quo_step;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  // Operand magnitudes; the most negative value maps onto itself as unsigned.
  always_comb begin
    a_neg = div_signed & dividend[WIDTH-1];
    b_neg = div_signed & divisor[WIDTH-1];
    a_mag = a_neg ? negate(dividend) : dividend;
    b_mag = b_neg ? negate(divisor) : divisor;
  end

  // One restoring step: dvd_q shifts dividend bits out and quotient bits in.
  always_comb begin
    trial    = {rem_q, dvd_q[WIDTH-1]};
    diff     = {1'b0, trial} - {2'b00, dsr_q};
    qbit     = ~diff[WIDTH+1];
    rem_step = qbit ? WIDTH'(diff) : WIDTH'(trial);
    quo_step = {dvd_q[WIDTH-2:0], qbit};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    rem_d   = rem_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    dz_d    = dz_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    case (state_q)
      IDLE: begin
        if (div_valid && !flush) begin
          state_d = CALC;
          cnt_d   = CNT_W'(WIDTH);
          dvd_d   = a_mag;
          dsr_d   = b_mag;
          rem_d   = '0;
          q_neg_d = a_neg ^ b_neg;
          r_neg_d = a_neg;
          dz_d    = (divisor == '0);
        end
      end
      CALC: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (dz_q) begin
          // Divide by zero: all-ones quotient, remainder is the raw dividend.
          state_d = DONE;
          quo_d   = '1;
          rmd_d   = r_neg_q ? negate(dvd_q) : dvd_q;
        end else begin
          dvd_d = quo_step;
          rem_d = rem_step;
          if (cnt_q == CNT_W'(1)) begin
            state_d = DONE;
            quo_d   = q_neg_q ? negate(quo_step) : quo_step;
            rmd_d   = r_neg_q ? negate(rem_step) : rem_step;
          end
        end
      end
      DONE: begin
        if (!stall_es) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      rem_q   <= rem_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
    end
  end

  assign stallreq_es = div_valid & (state_q != DONE) & ~flush;
  assign div_done    = done_q;
  assign quotient    = quo_q;
  assign remainder   = rmd_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed and random checks of div_unit with a result scoreboard.
module tb_div_unit;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
  } exp_t;

  logic        clk;
  logic        resetn;
  logic        flush;
  logic        stall_es;
  logic        div_valid;
  logic        div_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        stallreq_es;
  logic        div_done;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  div_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (flush),
    .stall_es   (stall_es),
    .div_valid  (div_valid),
    .div_signed (div_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .stallreq_es(stallreq_es),
    .div_done   (div_done),
    .quotient   (quotient),
    .remainder  (remainder)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sbv;
    sa  = a;
    sbv = b;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (sgn) return {32'(sa / sbv), 32'(sa % sbv)};
    return {a / b, a % b};
  endfunction

  // Called #1 after a rising edge; returns #1 after a rising edge.
  task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eq,
                        input logic [31:0] er, input int lat, input int nstall,
                        input bit keep);
    int   cyc;
    bit   seen;
    exp_t e;
    sb.push_back({eq, er});
    div_valid  = 1'b1;
    div_signed = sgn;
    dividend   = a;
    divisor    = b;
    cyc  = 0;
    seen = 0;
    while (cyc <= lat + 4) begin
      @(negedge clk);
      if (div_done) begin
        seen = 1;
        break;
      end
      chk({tag, "_stallreq_busy"}, 32'(stallreq_es), 32'd1);
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'(lat));
    if (sb.size() > 0) e = sb.pop_front();
    else e = '0;
    if (seen) begin
      chk({tag, "_stallreq_done"}, 32'(stallreq_es), 32'd0);
      chk({tag, "_q"}, quotient, e.q);
      chk({tag, "_r"}, remainder, e.r);
      if (nstall > 0) stall_es = 1'b1;
      for (int k = 0; k < nstall; k++) begin
        @(posedge clk);
        #1;
        if (k == nstall - 1) stall_es = 1'b0;
        @(negedge clk);
        chk({tag, "_hold_done"}, 32'(div_done), 32'd1);
        chk({tag, "_hold_stallreq"}, 32'(stallreq_es), 32'd0);
        chk({tag, "_hold_q"}, quotient, e.q);
        chk({tag, "_hold_r"}, remainder, e.r);
      end
    end
    @(posedge clk);
    #1;
    if (!keep) begin
      div_valid = 1'b0;
      @(negedge clk);
      chk({tag, "_done_cleared"}, 32'(div_done), 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [63:0] m;
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    bit          seen;

    resetn     = 1'b0;
    flush      = 1'b0;
    stall_es   = 1'b0;
    div_valid  = 1'b1;
    div_signed = 1'b0;
    dividend   = 32'd0;
    divisor    = 32'd0;
    #2;
    chk("rst_done", 32'(div_done), 32'd0);
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    chk("rst_stallreq_valid", 32'(stallreq_es), 32'd1);
    div_valid = 1'b0;
    #1;
    chk("rst_stallreq_idle", 32'(stallreq_es), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;

    do_div("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 0, 0);
    do_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 0, 0);
    do_div("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33, 0, 0);
    do_div("dz_u", 1'b0, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 2, 0, 0);
    do_div("dz_s", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 2, 0, 0);
    do_div("ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33, 0, 0);
    do_div("stall", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 33, 3, 0);

    // Flush in the tenth CALC cycle, then start a fresh division right away.
    div_valid  = 1'b1;
    div_signed = 1'b0;
    dividend   = 32'd1000;
    divisor    = 32'd3;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(negedge clk);
    chk("flush_stallreq", 32'(stallreq_es), 32'd0);
    chk("flush_done", 32'(div_done), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    m = model(1'b0, 32'd77777, 32'd13);
    do_div("after_flush", 1'b0, 32'd77777, 32'd13, m[63:32], m[31:0], 33, 0, 0);

    for (int i = 0; i < 8; i++) begin
      a   = $urandom;
      b   = $urandom >> $urandom_range(0, 28);
      sgn = 1'(i % 2);
      if (b == 32'd0) b = 32'd1;
      if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
      m = model(sgn, a, b);
      do_div($sformatf("rnd%0d", i), sgn, a, b, m[63:32], m[31:0], 33, 0, (i % 2) == 0);
    end

    // Reset in the middle of a division must discard it.
    div_valid  = 1'b1;
    div_signed = 1'b0;
    dividend   = 32'd999;
    divisor    = 32'd4;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    resetn = 1'b0;
    #1;
    chk("midrst_done", 32'(div_done), 32'd0);
    chk("midrst_q", quotient, 32'd0);
    chk("midrst_r", remainder, 32'd0);
    chk("midrst_stallreq", 32'(stallreq_es), 32'd1);
    div_valid = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (div_done) seen = 1;
    end
    chk("midrst_no_done", 32'(seen), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, operand and result width.
REQ-002 The block SHALL have these ports (name  direction  width  meaning):
  clk  in  1  clock, all state updates on the rising edge
  resetn  in  1  reset, asynchronous, active-low
  flush  in  1  pipeline flush from pipeline control; cancels any division
  stall_es  in  1  EX-stage stall bit from pipeline control; high means the EX instruction does not advance
  div_valid  in  1  the EX-stage instruction is a divide/modulo
  div_signed  in  1  1 = signed operands, 0 = unsigned
  dividend  in  WIDTH  numerator
  divisor  in  WIDTH  denominator
  stallreq_es  out  1  request to stall EX and everything upstream
  div_done  out  1  quotient and remainder are valid this cycle
  quotient  out  WIDTH  result quotient
  remainder  out  WIDTH  result remainder

Function
REQ-003 The block SHALL implement states IDLE, CALC and DONE, with a 6-bit iteration counter.
REQ-004 IDLE: if div_valid=1 and flush=0, the block SHALL latch operand magnitudes, result signs and a divide-by-zero flag, clear the partial remainder, load counter=WIDTH, and enter CALC; otherwise it SHALL stay in IDLE.
REQ-005 In signed mode, operand magnitudes SHALL be two's-complement absolute values taken as unsigned WIDTH-bit values; in unsigned mode the operands SHALL be used as given.
REQ-006 CALC SHALL perform one restoring-division step per cycle, MSB first: shift the partial remainder left, bring in the next dividend bit, subtract the divisor magnitude with one extra bit, and set the quotient bit when the result is non-negative.
REQ-007 CALC SHALL decrement the counter each cycle and enter DONE after the step where the counter reaches 1 (WIDTH CALC cycles).
REQ-008 If the divisor is zero, the block SHALL go from IDLE to DONE after one CALC cycle, with quotient all ones and remainder equal to dividend.
REQ-009 In DONE, div_done SHALL be 1 and quotient and remainder SHALL hold the final values, and the block SHALL return to IDLE on the next edge where stall_es=0.
REQ-010 In DONE with stall_es=1, the block SHALL stay in DONE with outputs held and no restart.
REQ-011 Signed result correction SHALL happen when entering DONE: quotient is negated if the operand signs differ, and remainder takes the sign of the dividend.
REQ-012 Signed overflow (0x80000000 / -1 at WIDTH=32) SHALL give quotient 0x80000000 and remainder 0, with no special case needed.
REQ-013 stallreq_es SHALL be combinational: div_valid AND (state != DONE) AND NOT flush.
REQ-014 flush=1 SHALL force state IDLE on the next edge from any state, and no start SHALL occur in that cycle.
REQ-015 Back-to-back divisions SHALL be supported: DONE, then IDLE, then a new start on the first IDLE cycle with div_valid=1.
REQ-016 quotient and remainder SHALL be registered outputs; outside DONE their values are don't-care for consumers but SHALL NOT be X after reset.

Reset
REQ-017 resetn=0 SHALL immediately force state IDLE, counter 0, div_done 0, quotient 0 and remainder 0, with stallreq_es then following REQ-013.
REQ-018 Deasserting resetn mid-CALC and then reasserting it SHALL discard the operation, and no div_done SHALL follow.

Verification
REQ-019 Unsigned 100/7 started at cycle 0 -> stallreq_es=1 for cycles 0..32; div_done=1 at cycle 33 with q=14, r=2, and stallreq_es=0 at cycle 33.
REQ-020 Signed -7/2 -> q=0xFFFFFFFD, r=0xFFFFFFFF; signed 7/-2 -> q=0xFFFFFFFD, r=1.
REQ-021 Divisor 0, dividend 0x1234 -> div_done at cycle 2, q=0xFFFFFFFF, r=0x1234.
REQ-022 Signed 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0.
REQ-023 flush=1 at CALC cycle 10 -> IDLE next cycle, stallreq_es=0 in the flush cycle, no div_done; a new division afterwards gives correct results.
REQ-024 stall_es=1 for 3 cycles during DONE -> div_done and results held for 4 cycles, no restart, then IDLE.
